// File: rtl/bus_stream_responder.sv
// Memory-mapped bridge between the core data bus and two byte streams:
// bus writes feed a TX FIFO drained by out_*, and in_* fills an RX FIFO that bus reads drain.
module bus_stream_responder #(
    parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000,
    parameter int          TX_DEPTH     = 16,
    parameter int          RX_DEPTH     = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic [3:0]  bus_byte_enable,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic [31:0] bus_read_data,
    output logic        bus_hit,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready
);

    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);

    localparam logic [TXW:0]   TX_FULL_COUNT = (TXW+1)'(TX_DEPTH);
    localparam logic [RXW:0]   RX_FULL_COUNT = (RXW+1)'(RX_DEPTH);
    localparam logic [TXW:0]   TX_COUNT_ONE  = (TXW+1)'(1);
    localparam logic [RXW:0]   RX_COUNT_ONE  = (RXW+1)'(1);
    localparam logic [TXW-1:0] TX_PTR_ONE    = TXW'(1);
    localparam logic [RXW-1:0] RX_PTR_ONE    = RXW'(1);

    localparam logic [1:0] OFFSET_TXDATA  = 2'd0;
    localparam logic [1:0] OFFSET_RXDATA  = 2'd1;
    localparam logic [1:0] OFFSET_STATUS  = 2'd2;
    localparam logic [1:0] OFFSET_CONTROL = 2'd3;

    // Storage and state
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [TXW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [RXW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [TXW:0]   tx_count_reg;
    logic [RXW:0]   rx_count_reg;
    logic [7:0]     tx_drop_count_reg;
    logic [31:0]    bus_read_data_reg;
    logic           bus_hit_reg;

    // Decode
    logic        in_window;
    logic [1:0]  offset;
    logic        write_access, read_access;
    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic        tx_push_req, tx_push, tx_drop, tx_pop;
    logic        rx_push, rx_pop;
    logic        control_write, tx_flush, rx_flush, drop_clear;
    logic [7:0]  rx_head;
    logic [31:0] status_word;
    logic [31:0] bus_read_data_next;
    logic        bus_hit_next;

    assign in_window    = (bus_address[31:4] == BASE_ADDRESS[31:4]);
    assign offset       = bus_address[3:2];
    assign write_access = in_window & bus_write_enable;
    // A simultaneous write wins; the read is discarded entirely.
    assign read_access  = in_window & bus_read_enable & ~bus_write_enable;

    assign tx_empty = (tx_count_reg == '0);
    assign tx_full  = (tx_count_reg == TX_FULL_COUNT);
    assign rx_empty = (rx_count_reg == '0);
    assign rx_full  = (rx_count_reg == RX_FULL_COUNT);

    assign tx_push_req = write_access & (offset == OFFSET_TXDATA) & bus_byte_enable[0];
    assign tx_push     = tx_push_req & ~tx_full;
    assign tx_drop     = tx_push_req & tx_full;
    assign tx_pop      = ~tx_empty & out_ready;

    assign rx_push = ~rx_full & in_valid;
    assign rx_pop  = read_access & (offset == OFFSET_RXDATA) & ~rx_empty;

    assign control_write = write_access & (offset == OFFSET_CONTROL) & bus_byte_enable[0];
    assign tx_flush      = control_write & bus_write_data[0];
    assign rx_flush      = control_write & bus_write_data[1];
    assign drop_clear    = control_write & bus_write_data[2];

    assign rx_head     = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr_reg];
    assign status_word = {16'h0000, tx_drop_count_reg, 4'h0, rx_full, rx_empty, tx_full, tx_empty};

    always_comb begin
        bus_read_data_next = 32'h0000_0000;
        bus_hit_next       = 1'b0;
        if (read_access) begin
            bus_hit_next = 1'b1;
            case (offset)
                OFFSET_RXDATA: bus_read_data_next = {rx_empty, 23'h000000, rx_head};
                OFFSET_STATUS: bus_read_data_next = status_word;
                default:       bus_read_data_next = 32'h0000_0000;
            endcase
        end
    end

    // FIFO storage carries no reset; emptiness is tracked by the counts alone.
    always_ff @(posedge clock) begin
        if (tx_push)
            tx_mem[tx_wr_ptr_reg] <= bus_write_data[7:0];
        if (rx_push)
            rx_mem[rx_wr_ptr_reg] <= in_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
        end else if (tx_flush) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= '0;
        end else begin
            if (tx_push)
                tx_wr_ptr_reg <= tx_wr_ptr_reg + TX_PTR_ONE;
            if (tx_pop)
                tx_rd_ptr_reg <= tx_rd_ptr_reg + TX_PTR_ONE;
            case ({tx_push, tx_pop})
                2'b10:   tx_count_reg <= tx_count_reg + TX_COUNT_ONE;
                2'b01:   tx_count_reg <= tx_count_reg - TX_COUNT_ONE;
                default: tx_count_reg <= tx_count_reg;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
        end else if (rx_flush) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= '0;
        end else begin
            if (rx_push)
                rx_wr_ptr_reg <= rx_wr_ptr_reg + RX_PTR_ONE;
            if (rx_pop)
                rx_rd_ptr_reg <= rx_rd_ptr_reg + RX_PTR_ONE;
            case ({rx_push, rx_pop})
                2'b10:   rx_count_reg <= rx_count_reg + RX_COUNT_ONE;
                2'b01:   rx_count_reg <= rx_count_reg - RX_COUNT_ONE;
                default: rx_count_reg <= rx_count_reg;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            tx_drop_count_reg <= 8'h00;
        else if (drop_clear)
            tx_drop_count_reg <= 8'h00;
        else if (tx_drop && (tx_drop_count_reg != 8'hFF))
            tx_drop_count_reg <= tx_drop_count_reg + 8'h01;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_read_data_reg <= 32'h0000_0000;
            bus_hit_reg       <= 1'b0;
        end else begin
            bus_read_data_reg <= bus_read_data_next;
            bus_hit_reg       <= bus_hit_next;
        end
    end

    assign bus_read_data = bus_read_data_reg;
    assign bus_hit       = bus_hit_reg;
    assign out_data      = tx_mem[tx_rd_ptr_reg];
    assign out_valid     = ~tx_empty;
    assign in_ready      = ~rx_full;

    // Address byte lanes and upper data bits are architecturally ignored.
    logic unused_bits;
    assign unused_bits = ^{bus_address[1:0], bus_write_data[31:8], bus_byte_enable[3:1]};

endmodule

// File: tb/tb_bus_stream_responder.sv
// Directed bench for bus_stream_responder: register map, FIFO limits, drop counter,
// flush control, read/write collision, window decode and asynchronous reset.
module tb_bus_stream_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [31:0] bus_read_data;
    logic        bus_hit;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;

    int pass_count  = 0;
    int fail_count  = 0;
    int check_count = 0;

    always #5 clock = ~clock;

    bus_stream_responder #(
        .BASE_ADDRESS (BASE),
        .TX_DEPTH     (16),
        .RX_DEPTH     (16)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_byte_enable  (bus_byte_enable),
        .bus_read_enable  (bus_read_enable),
        .bus_write_enable (bus_write_enable),
        .bus_read_data    (bus_read_data),
        .bus_hit          (bus_hit),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge clock);
        bus_address      = addr;
        bus_write_data   = data;
        bus_byte_enable  = be;
        bus_write_enable = 1'b1;
        @(negedge clock);
        bus_write_enable = 1'b0;
        $display("wr addr=%08h data=%08h be=%b", addr, data, be);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic hit);
        @(negedge clock);
        bus_address     = addr;
        bus_read_enable = 1'b1;
        @(negedge clock);
        bus_read_enable = 1'b0;
        data = bus_read_data;
        hit  = bus_hit;
        $display("rd addr=%08h data=%08h hit=%b", addr, data, hit);
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        logic [31:0] data;
        logic        hit;
        bus_read(addr, data, hit);
        check({tag, "_data"}, data, expected);
        check({tag, "_hit"}, {31'd0, hit}, 32'd1);
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(negedge clock);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        $display("rx offer data=%02h", b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b0;
        bus_address      = 32'h0;
        bus_write_data   = 32'h0;
        bus_byte_enable  = 4'h0;
        bus_read_enable  = 1'b0;
        bus_write_enable = 1'b0;
        out_ready        = 1'b0;
        in_data          = 8'h00;
        in_valid         = 1'b0;
        #12;
        check("reset_rdata", bus_read_data, 32'h0);
        check("reset_hit", {31'd0, bus_hit}, 32'd0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        reset = 1'b1;

        // TX ordering through the stream port
        bus_write(BASE, 32'h41, 4'b0001);
        bus_write(BASE, 32'h42, 4'b0001);
        bus_write(BASE, 32'h43, 4'b0001);
        check("tx_valid_held", {31'd0, out_valid}, 32'd1);
        check("tx_head_41", {24'd0, out_data}, 32'h41);
        out_ready = 1'b1;
        @(negedge clock);
        check("tx_head_42", {24'd0, out_data}, 32'h42);
        @(negedge clock);
        check("tx_head_43", {24'd0, out_data}, 32'h43);
        @(negedge clock);
        check("tx_drained", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Overfill TX: 16 stored, 3 dropped
        for (int i = 0; i < 19; i++)
            bus_write(BASE, i, 4'b0001);
        read_check("status_overfill", BASE + 32'h8, 32'h0000_0306);
        check("tx_head_0", {24'd0, out_data}, 32'h00);

        // Full FIFO: same-edge pop does not rescue the push
        @(negedge clock);
        out_ready        = 1'b1;
        bus_address      = BASE;
        bus_write_data   = 32'hEE;
        bus_byte_enable  = 4'b0001;
        bus_write_enable = 1'b1;
        @(negedge clock);
        out_ready        = 1'b0;
        bus_write_enable = 1'b0;
        read_check("status_pop_drop", BASE + 32'h8, 32'h0000_0404);
        check("tx_head_1", {24'd0, out_data}, 32'h01);

        // Drop counter saturation, then clear and flush
        for (int i = 0; i < 300; i++)
            bus_write(BASE, 32'hA0, 4'b0001);
        read_check("status_saturated", BASE + 32'h8, 32'h0000_FF06);
        bus_write(BASE + 32'hC, 32'h4, 4'b0001);
        read_check("status_drop_clr", BASE + 32'h8, 32'h0000_0006);
        bus_write(BASE + 32'hC, 32'h1, 4'b0001);
        read_check("status_tx_flush", BASE + 32'h8, 32'h0000_0005);
        bus_write(BASE, 32'h55, 4'b1110);
        check("tx_be0_low_ignored", {31'd0, out_valid}, 32'd0);

        // RX path
        rx_push(8'h5A);
        rx_push(8'hA5);
        read_check("rx_first", BASE + 32'h4, 32'h0000_005A);
        read_check("rx_second", BASE + 32'h4, 32'h0000_00A5);
        read_check("rx_empty", BASE + 32'h4, 32'h8000_0000);
        for (int i = 0; i < 15; i++)
            rx_push(8'h80 + 8'(i));
        check("rx_ready_15", {31'd0, in_ready}, 32'd1);
        rx_push(8'h8F);
        check("rx_ready_full", {31'd0, in_ready}, 32'd0);
        rx_push(8'hEE);
        read_check("status_rx_full", BASE + 32'h8, 32'h0000_0009);
        read_check("rx_head_after_full", BASE + 32'h4, 32'h0000_0080);
        check("rx_ready_after_pop", {31'd0, in_ready}, 32'd1);

        // Combined flush with both FIFOs occupied
        bus_write(BASE, 32'h66, 4'b0001);
        bus_write(BASE + 32'hC, 32'h7, 4'b0001);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        read_check("status_flush_all", BASE + 32'h8, 32'h0000_0005);

        // Read and write together: write happens, read ignored
        @(negedge clock);
        bus_address      = BASE;
        bus_write_data   = 32'h77;
        bus_byte_enable  = 4'b0001;
        bus_write_enable = 1'b1;
        bus_read_enable  = 1'b1;
        @(negedge clock);
        bus_write_enable = 1'b0;
        bus_read_enable  = 1'b0;
        check("rw_tx_hit", {31'd0, bus_hit}, 32'd0);
        check("rw_tx_pushed", {23'd0, out_valid, out_data}, 32'h177);
        rx_push(8'h33);
        @(negedge clock);
        bus_address      = BASE + 32'h4;
        bus_write_enable = 1'b1;
        bus_read_enable  = 1'b1;
        @(negedge clock);
        bus_write_enable = 1'b0;
        bus_read_enable  = 1'b0;
        check("rw_rx_hit", {31'd0, bus_hit}, 32'd0);
        read_check("rw_rx_not_popped", BASE + 32'h4, 32'h0000_0033);

        // Window decode
        bus_write(32'h2000_0000, 32'h99, 4'b0001);
        read_check("read_txdata_zero", BASE, 32'h0);
        @(negedge clock);
        bus_address     = BASE + 32'h8;
        bus_read_enable = 1'b1;
        @(negedge clock);
        check("win_in_hit", {31'd0, bus_hit}, 32'd1);
        check("win_in_status", bus_read_data, 32'h0000_0004);
        bus_address = 32'h2000_0000;
        @(negedge clock);
        bus_read_enable = 1'b0;
        check("win_out_hit", {31'd0, bus_hit}, 32'd0);
        check("win_out_data", bus_read_data, 32'h0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 16; i++)
            rx_push(8'(i));
        check("pre_reset_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clock);
        bus_address     = BASE + 32'h8;
        bus_read_enable = 1'b1;
        @(posedge clock);
        #2;
        bus_read_enable = 1'b0;
        check("pre_reset_hit", {31'd0, bus_hit}, 32'd1);
        reset = 1'b0;
        #1;
        check("async_rst_hit", {31'd0, bus_hit}, 32'd0);
        check("async_rst_rdata", bus_read_data, 32'h0);
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        read_check("status_after_reset", BASE + 32'h8, 32'h0000_0005);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
